aquarium_pump_driver: RTL and testbench
=======================================

Name: aquarium_pump_driver

Overview:
- Actuator-side block that consumes the thermal controller's pump requests (`pump_control_hot`, `pump_control_cold`) and drives the physical hot and cold pump enables.
- Enforces minimum on-time and minimum off-time, measured in 1-tick units from an internal prescaler.
- Enforces hot/cold mutual exclusion and dry-run protection.
- Sits between the controller and the pump relay pins.

Parameters:
- TICK_DIV, 50000000: clk cycles per timing tick (1 s at 50 MHz); legal values ≥2.
- MIN_ON, 5: minimum pump on-time in ticks; legal values ≥1.
- MIN_OFF, 10: minimum off-time after any pump stops, in ticks; legal values ≥1.
- TMR_W, 8: tick-timer width; MIN_ON and MIN_OFF must fit in it.
- RT_W, 24: runtime counter width (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- pump_control_hot  in  1  hot pump request, level.
- pump_control_cold  in  1  cold pump request, level.
- water_level_ok  in  1  1 = water present; 0 = dry.
- hot_pump_en  out  1  hot pump relay drive.
- cold_pump_en  out  1  cold pump relay drive.
- dry_fault  out  1  high while in FAULT.
- req_conflict  out  1  high on any cycle after a clock edge at which both requests were sampled high.
- pump_state  out  3  encoded state: IDLE=0, HOT_ON=1, COLD_ON=2, COOLDOWN=3, FAULT=4.

Behaviour:
- Reset (clr=1 at a clock edge):
  - State goes to IDLE; prescaler and timer clear.
  - All outputs are 0 on the next cycle.
  - Applies mid-operation and overrides all timers.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (presc == TICK_DIV-1).
  - Forced to 0 on every state transition, so timing is exact per state.
- Timer (tmr):
  - Loaded on state entry.
  - Decrements on tick and saturates at 0.
- Outputs:
  - All outputs are registered and decoded from the next state, so they change on the same edge as pump_state.
  - Request-to-output latency is 1 clk.
- Request decode:
  - hot_req = pump_control_hot & ~pump_control_cold.
  - cold_req = the mirror of hot_req.
  - Both requests high counts as no request and sets req_conflict.
- Priority: water_level_ok==0 beats everything except clr. From any state, the next state is FAULT and both enables go 0 on the next edge, even if MIN_ON has not elapsed.
- IDLE:
  - Both enables are 0.
  - hot_req → HOT_ON with tmr=MIN_ON.
  - cold_req → COLD_ON with tmr=MIN_ON.
  - Otherwise stay in IDLE.
- HOT_ON:
  - hot_pump_en=1.
  - Stay while hot_req is high or tmr≠0.
  - When tmr==0 and hot_req is low → COOLDOWN with tmr=MIN_OFF.
  - A cold request never switches directly to COLD_ON.
- COLD_ON: symmetric to HOT_ON, with cold_pump_en=1.
- COOLDOWN:
  - Both enables are 0.
  - When tmr==0 → IDLE, regardless of requests.
- FAULT:
  - Both enables are 0; dry_fault=1.
  - When water_level_ok==1 → COOLDOWN with tmr=MIN_OFF.
- Derived timing:
  - A pump whose request drops early stays on exactly MIN_ON·TICK_DIV cycles.
  - The minimum gap between a pump dropping and either pump re-enabling is MIN_OFF·TICK_DIV+1 cycles (the +1 is the IDLE cycle).
- Invariant: hot_pump_en & cold_pump_en is never 1.

Optional Feature:
- Macro: PUMP_RUNTIME_EN.
- When defined, add two output ports:
  - hot_runtime [RT_W-1:0]: increments on each tick while in HOT_ON.
  - cold_runtime [RT_W-1:0]: increments on each tick while in COLD_ON.
  - Both saturate at all-ones and are cleared only by clr.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
Bench parameters: TICK_DIV=4, MIN_ON=2, MIN_OFF=3.
1. Reset: hold clr=1 for 3 cycles with both requests high → all outputs 0 and pump_state=0. After clr drops, req_conflict=1 and both enables stay 0.
2. Short hot request: pump_control_hot=1 for 1 cycle → hot_pump_en high exactly 8 cycles, then pump_state=3 for 12 cycles, then 0.
3. Sustained cold request: hold for 30 cycles then drop → cold_pump_en high for 30 cycles plus 1 cycle of latency, then COOLDOWN for 12 cycles. A hot request raised during COOLDOWN gives hot_pump_en=1 only 13 cycles after cold_pump_en falls.
4. Dry run: water_level_ok=0 on cycle 3 of HOT_ON → hot_pump_en=0 and dry_fault=1 on the next edge. Restore water_level_ok=1 → COOLDOWN for 12 cycles, then IDLE.
5. Direction change: cold request raised while HOT_ON with tmr≠0 → hot stays on until MIN_ON expires, then COOLDOWN, and cold_pump_en never overlaps hot_pump_en.
6. Runtime (PUMP_RUNTIME_EN): hot request held for 20 cycles (5 ticks) → hot_runtime=5 and cold_runtime=0; clr then clears both to 0.

Source files
------------

// File: rtl/aquarium_pump_driver.sv
// rtl/aquarium_pump_driver.sv - hot/cold pump relay driver with minimum on/off timing and dry-run protection
//
// Purpose: turns the thermal controller's level requests into relay enables,
// holding each pump on for at least MIN_ON ticks, keeping both pumps off for
// at least MIN_OFF ticks after any stop, never driving both pumps at once and
// dropping both immediately when the tank runs dry.
//
// Optional feature macro: PUMP_RUNTIME_EN (adds hot_runtime / cold_runtime).
//
// Ports:
//   clk                in   system clock, rising edge
//   clr                in   synchronous active-high reset
//   pump_control_hot   in   hot pump request (level)
//   pump_control_cold  in   cold pump request (level)
//   water_level_ok     in   1 = water present, 0 = dry
//   hot_pump_en        out  hot pump relay drive
//   cold_pump_en       out  cold pump relay drive
//   dry_fault          out  high while in FAULT
//   req_conflict       out  both requests were high at the previous edge
//   hot_runtime        out  ticks spent in HOT_ON, saturating (PUMP_RUNTIME_EN only)
//   cold_runtime       out  ticks spent in COLD_ON, saturating (PUMP_RUNTIME_EN only)
//   pump_state         out  IDLE=0, HOT_ON=1, COLD_ON=2, COOLDOWN=3, FAULT=4

module aquarium_pump_driver #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MIN_ON   = 5,
    parameter int unsigned MIN_OFF  = 10,
    parameter int unsigned TMR_W    = 8,
    parameter int unsigned RT_W     = 24
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            pump_control_hot,
    input  logic            pump_control_cold,
    input  logic            water_level_ok,
    output logic            hot_pump_en,
    output logic            cold_pump_en,
    output logic            dry_fault,
    output logic            req_conflict,
`ifdef PUMP_RUNTIME_EN
    output logic [RT_W-1:0] hot_runtime,
    output logic [RT_W-1:0] cold_runtime,
`endif
    output logic [2:0]      pump_state
);

    localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [TMR_W-1:0]   TMR_ON    = TMR_W'(MIN_ON);
    localparam logic [TMR_W-1:0]   TMR_OFF   = TMR_W'(MIN_OFF);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOT_ON   = 3'd1,
        ST_COLD_ON  = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               hot_en_q, hot_en_d;
    logic               cold_en_q, cold_en_d;
    logic               dry_q, dry_d;
    logic               conflict_q, conflict_d;

    logic               tick;
    logic [TMR_W-1:0]   tmr_dec;
    logic               tmr_done;
    logic               hot_req;
    logic               cold_req;

    always_comb begin
        tick     = (presc_q == PRESC_MAX);
        // Exit decisions look at the timer value after this edge's tick, so a
        // pump whose request drops early is on for exactly MIN_ON*TICK_DIV cycles.
        tmr_dec  = (tick && (tmr_q != '0)) ? tmr_q - 1'b1 : tmr_q;
        tmr_done = (tmr_dec == '0);
        hot_req  = pump_control_hot & ~pump_control_cold;
        cold_req = pump_control_cold & ~pump_control_hot;

        state_d = state_q;
        if (!water_level_ok) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hot_req) begin
                        state_d = ST_HOT_ON;
                    end else if (cold_req) begin
                        state_d = ST_COLD_ON;
                    end
                end
                ST_HOT_ON: begin
                    if (!hot_req && tmr_done) begin
                        state_d = ST_COOLDOWN;
                    end
                end
                ST_COLD_ON: begin
                    if (!cold_req && tmr_done) begin
                        state_d = ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (tmr_done) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: state_d = ST_COOLDOWN;
                default:  state_d = ST_IDLE;
            endcase
        end

        tmr_d   = tmr_dec;
        presc_d = tick ? '0 : presc_q + 1'b1;
        // Every state starts its timing from a fresh prescaler phase.
        if (state_d != state_q) begin
            presc_d = '0;
            case (state_d)
                ST_HOT_ON, ST_COLD_ON: tmr_d = TMR_ON;
                ST_COOLDOWN:           tmr_d = TMR_OFF;
                default:               tmr_d = '0;
            endcase
        end

        hot_en_d   = (state_d == ST_HOT_ON);
        cold_en_d  = (state_d == ST_COLD_ON);
        dry_d      = (state_d == ST_FAULT);
        conflict_d = pump_control_hot & pump_control_cold;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            tmr_q      <= '0;
            hot_en_q   <= 1'b0;
            cold_en_q  <= 1'b0;
            dry_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tmr_q      <= tmr_d;
            hot_en_q   <= hot_en_d;
            cold_en_q  <= cold_en_d;
            dry_q      <= dry_d;
            conflict_q <= conflict_d;
        end
    end

    assign hot_pump_en  = hot_en_q;
    assign cold_pump_en = cold_en_q;
    assign dry_fault    = dry_q;
    assign req_conflict = conflict_q;
    assign pump_state   = state_q;

`ifdef PUMP_RUNTIME_EN
    logic [RT_W-1:0] hot_rt_q, hot_rt_d;
    logic [RT_W-1:0] cold_rt_q, cold_rt_d;

    always_comb begin
        hot_rt_d  = hot_rt_q;
        cold_rt_d = cold_rt_q;
        if (tick && (state_q == ST_HOT_ON) && (hot_rt_q != '1)) begin
            hot_rt_d = hot_rt_q + 1'b1;
        end
        if (tick && (state_q == ST_COLD_ON) && (cold_rt_q != '1)) begin
            cold_rt_d = cold_rt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hot_rt_q  <= '0;
            cold_rt_q <= '0;
        end else begin
            hot_rt_q  <= hot_rt_d;
            cold_rt_q <= cold_rt_d;
        end
    end

    assign hot_runtime  = hot_rt_q;
    assign cold_runtime = cold_rt_q;
`endif

endmodule

// File: tb/tb_aquarium_pump_driver.sv
// tb/tb_aquarium_pump_driver.sv - self-checking bench for aquarium_pump_driver

module tb_aquarium_pump_driver;

    localparam int TICK_DIV = 4;
    localparam int MIN_ON   = 2;
    localparam int MIN_OFF  = 3;
    localparam int TMR_W    = 8;
    localparam int RT_W     = 24;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic pump_control_hot = 1'b1;
    logic pump_control_cold = 1'b1;
    logic water_level_ok = 1'b1;
    logic hot_pump_en, cold_pump_en, dry_fault, req_conflict;
    logic [2:0] pump_state;
`ifdef PUMP_RUNTIME_EN
    logic [RT_W-1:0] hot_runtime, cold_runtime;
`endif

    aquarium_pump_driver #(
        .TICK_DIV(TICK_DIV), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
        .TMR_W(TMR_W), .RT_W(RT_W)
    ) dut (
        .clk(clk),
        .clr(clr),
        .pump_control_hot(pump_control_hot),
        .pump_control_cold(pump_control_cold),
        .water_level_ok(water_level_ok),
        .hot_pump_en(hot_pump_en),
        .cold_pump_en(cold_pump_en),
        .dry_fault(dry_fault),
        .req_conflict(req_conflict),
`ifdef PUMP_RUNTIME_EN
        .hot_runtime(hot_runtime),
        .cold_runtime(cold_runtime),
`endif
        .pump_state(pump_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode plus minimum residency counted directly in clk cycles.
    int m_state = 0;
    int m_left = 0;
    int m_age = 0;
    bit m_conf = 0;
    bit m_started = 0;
    int m_hrt = 0;
    int m_crt = 0;
    localparam int RT_MAX = (1 << RT_W) - 1;

    always @(posedge clk) begin
        int nxt;
        bit hr, cr;
        hr = pump_control_hot & ~pump_control_cold;
        cr = pump_control_cold & ~pump_control_hot;
        m_started = 1;
        if (clr) begin
            m_state = 0; m_left = 0; m_age = 0; m_conf = 0; m_hrt = 0; m_crt = 0;
        end else begin
            m_conf = pump_control_hot & pump_control_cold;
            m_left = (m_left > 0) ? m_left - 1 : 0;
            m_age++;
            if (m_age % TICK_DIV == 0) begin
                if (m_state == 1 && m_hrt < RT_MAX) m_hrt++;
                if (m_state == 2 && m_crt < RT_MAX) m_crt++;
            end
            nxt = m_state;
            if (!water_level_ok) nxt = 4;
            else case (m_state)
                0: if (hr) nxt = 1; else if (cr) nxt = 2;
                1: if (!hr && m_left == 0) nxt = 3;
                2: if (!cr && m_left == 0) nxt = 3;
                3: if (m_left == 0) nxt = 0;
                default: nxt = 3;
            endcase
            if (nxt != m_state) begin
                m_age = 0;
                m_left = (nxt == 1 || nxt == 2) ? MIN_ON * TICK_DIV :
                         (nxt == 3) ? MIN_OFF * TICK_DIV : 0;
            end
            m_state = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("pump_state", 32'(pump_state), 32'(m_state));
            chk("hot_pump_en", 32'(hot_pump_en), 32'(m_state == 1));
            chk("cold_pump_en", 32'(cold_pump_en), 32'(m_state == 2));
            chk("dry_fault", 32'(dry_fault), 32'(m_state == 4));
            chk("req_conflict", 32'(req_conflict), 32'(m_conf));
            chk("no_overlap", 32'(hot_pump_en & cold_pump_en), 32'd0);
`ifdef PUMP_RUNTIME_EN
            chk("hot_runtime", 32'(hot_runtime), 32'(m_hrt));
            chk("cold_runtime", 32'(cold_runtime), 32'(m_crt));
`endif
        end
    end

    function automatic bit sig(input int sel);
        case (sel)
            0:       return hot_pump_en === 1'b1;
            1:       return cold_pump_en === 1'b1;
            2:       return pump_state === 3'd3;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_len(input int sel, input int max, output int n);
        n = 0;
        while (sig(sel) && n < max) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pump_state !== 3'd0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle", 32'(pump_state), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g;
        // 1. reset with both requests high
        repeat (4) @(negedge clk);
        chk("rst_state", 32'(pump_state), 32'd0);
        chk("rst_hot", 32'(hot_pump_en), 32'd0);
        chk("rst_cold", 32'(cold_pump_en), 32'd0);
        chk("rst_dry", 32'(dry_fault), 32'd0);
        chk("rst_conflict", 32'(req_conflict), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("conflict_set", 32'(req_conflict), 32'd1);
        chk("conflict_hot_off", 32'(hot_pump_en), 32'd0);
        chk("conflict_cold_off", 32'(cold_pump_en), 32'd0);
        pump_control_hot = 1'b0;
        pump_control_cold = 1'b0;
        @(negedge clk);
        chk("conflict_clear", 32'(req_conflict), 32'd0);

        // 2. one-cycle hot request
        pump_control_hot = 1'b1;
        @(negedge clk);
        pump_control_hot = 1'b0;
        run_len(0, 50, n);
        chk("t2_hot_len", 32'(n), 32'd8);
        run_len(2, 50, n);
        chk("t2_cooldown_len", 32'(n), 32'd12);
        chk("t2_idle", 32'(pump_state), 32'd0);

        // 3. sustained cold request, then hot raised during cooldown
        pump_control_cold = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (cold_pump_en === 1'b1) n++;
        end
        pump_control_cold = 1'b0;
        @(negedge clk);
        chk("t3_cold_len", 32'(n), 32'd30);
        chk("t3_cold_off", 32'(cold_pump_en), 32'd0);
        chk("t3_cooldown", 32'(pump_state), 32'd3);
        pump_control_hot = 1'b1;
        g = 0;
        while (hot_pump_en !== 1'b1 && g < 50) begin
            g++;
            @(negedge clk);
        end
        chk("t3_gap", 32'(g), 32'd13);
        pump_control_hot = 1'b0;
        wait_idle();

        // 4. dry run on the third HOT_ON cycle
        pump_control_hot = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_hot_on", 32'(hot_pump_en), 32'd1);
        water_level_ok = 1'b0;
        @(negedge clk);
        chk("t4_hot_off", 32'(hot_pump_en), 32'd0);
        chk("t4_dry", 32'(dry_fault), 32'd1);
        chk("t4_state", 32'(pump_state), 32'd4);
        pump_control_hot = 1'b0;
        repeat (2) @(negedge clk);
        water_level_ok = 1'b1;
        @(negedge clk);
        run_len(2, 50, n);
        chk("t4_cooldown_len", 32'(n), 32'd12);
        chk("t4_idle", 32'(pump_state), 32'd0);

        // 5. direction change while MIN_ON is running
        pump_control_hot = 1'b1;
        @(negedge clk);
        pump_control_hot = 1'b0;
        pump_control_cold = 1'b1;
        run_len(0, 50, n);
        chk("t5_hot_len", 32'(n), 32'd8);
        run_len(2, 50, n);
        chk("t5_cooldown_len", 32'(n), 32'd12);
        chk("t5_idle", 32'(pump_state), 32'd0);
        @(negedge clk);
        chk("t5_cold_on", 32'(cold_pump_en), 32'd1);
        pump_control_cold = 1'b0;
        wait_idle();

        // 6. clean start, five-tick hot run, then mid-operation reset
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pump_control_hot = 1'b1;
        repeat (20) @(negedge clk);
        pump_control_hot = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_cooldown", 32'(pump_state), 32'd3);
`ifdef PUMP_RUNTIME_EN
        chk("t6_hot_runtime", 32'(hot_runtime), 32'd5);
        chk("t6_cold_runtime", 32'(cold_runtime), 32'd0);
`endif
        pump_control_cold = 1'b1;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("t6_clr_state", 32'(pump_state), 32'd0);
        chk("t6_clr_cold", 32'(cold_pump_en), 32'd0);
`ifdef PUMP_RUNTIME_EN
        chk("t6_clr_hot_runtime", 32'(hot_runtime), 32'd0);
        chk("t6_clr_cold_runtime", 32'(cold_runtime), 32'd0);
`endif
        clr = 1'b0;
        @(negedge clk);
        chk("t6_after_clr_cold", 32'(cold_pump_en), 32'd1);
        pump_control_cold = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
